// File: rtl/chip8_pkg.sv
// Screen geometry and blitter state encodings shared by the CHIP-8 drawing engine.
package chip8_pkg;

    localparam int SCR_W     = 64;
    localparam int SCR_H     = 32;
    localparam int ROW_BYTES = SCR_W / 8;
    localparam int FB_BYTES  = SCR_W * SCR_H / 8;
    localparam int MEM_AW    = 12;
    localparam int FB_AW     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SPR_RD,
        ST_FB_RD0,
        ST_FB_RD1,
        ST_WR0,
        ST_WR1,
        ST_DONE
    } blit_state_e;

endpackage

// File: rtl/blit_row_merge.sv
// Combinational XOR merge of one sprite byte into the one or two framebuffer bytes it
// straddles, with right-edge clipping of the spill byte and collision detection.
module blit_row_merge
    import chip8_pkg::*;
(
    input  logic [7:0] s,
    input  logic [2:0] x_bit,
    input  logic       spill_en,
    input  logic [7:0] f0,
    input  logic [7:0] f1,
    output logic [7:0] w0,
    output logic [7:0] w1,
    output logic       coll
);

    logic [15:0] sh;
    logic [7:0]  sh0;
    logic [7:0]  sh1;

    // Upper byte lands in the first framebuffer byte, lower byte spills into the next one.
    assign sh   = {s, 8'h00} >> x_bit;
    assign sh0  = sh[15:8];
    assign sh1  = sh[7:0] & {8{spill_en}};

    assign w0   = f0 ^ sh0;
    assign w1   = f1 ^ sh1;
    assign coll = (|(f0 & sh0)) | (|(f1 & sh1));

endmodule

// File: rtl/sprite_blitter.sv
// CHIP-8 drawing engine: DXYN XOR sprite draw with collision, and 00E0 screen clear,
// on a 64x32 byte-packed framebuffer.
//
//   state  | meaning
//   IDLE   | waiting for draw_start / clear_start
//   CLEAR  | writing 0x00 to one framebuffer byte per cycle
//   SPR_RD | reading sprite row r from memory
//   FB_RD0 | reading first framebuffer byte of the row
//   FB_RD1 | reading spill byte (unaligned, not right-clipped)
//   WR0    | writing merged first byte
//   WR1    | writing merged spill byte
//   DONE   | one-cycle done pulse
module sprite_blitter
    import chip8_pkg::*;
#(
    parameter int MEM_AW    = chip8_pkg::MEM_AW,
    parameter int FB_AW     = chip8_pkg::FB_AW,
    parameter int ROW_BYTES = chip8_pkg::ROW_BYTES,
    parameter int ROWS      = chip8_pkg::SCR_H
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              draw_start,
    input  logic              clear_start,
    input  logic [7:0]        draw_x,
    input  logic [7:0]        draw_y,
    input  logic [3:0]        draw_n,
    input  logic [MEM_AW-1:0] draw_addr,
    output logic              busy,
    output logic              done,
    output logic              collision,
    output logic              mem_rd,
    output logic [MEM_AW-1:0] mem_addr,
    input  logic [7:0]        mem_data,
    output logic              fb_rd,
    output logic              fb_we,
    output logic [FB_AW-1:0]  fb_addr,
    output logic [7:0]        fb_wdata,
    input  logic [7:0]        fb_rdata
);

    blit_state_e       state_q, state_d;
    logic [5:0]        x0_q, x0_d;
    logic [4:0]        y_q, y_d;
    logic [3:0]        r_q, r_d;
    logic [3:0]        n_q, n_d;
    logic [7:0]        s_q, s_d;
    logic [7:0]        f0_q, f0_d;
    logic              coll_q, coll_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              mem_rd_q, mem_rd_d;
    logic [MEM_AW-1:0] mem_addr_q, mem_addr_d;
    logic              fb_rd_q, fb_rd_d;
    logic              fb_we_q, fb_we_d;
    logic [FB_AW-1:0]  fb_addr_q, fb_addr_d;
    logic [7:0]        fb_wdata_q, fb_wdata_d;

    logic              two;
    logic              spill_en;
    logic              y_last;
    logic              row_end;
    logic [FB_AW-1:0]  b0;
    logic [7:0]        m_f0;
    logic [7:0]        m_w0;
    logic [7:0]        m_w1;
    logic              m_coll;

    assign spill_en = (x0_q[5:3] != 3'd7);
    assign two      = (x0_q[2:0] != 3'd0) && spill_en;
    assign y_last   = (y_q == 5'(ROWS - 1));
    assign b0       = FB_AW'(y_q) * FB_AW'(ROW_BYTES) + FB_AW'(x0_q[5:3]);

    // In WR0 the live read data is f0 for a single-byte row, or the spill byte otherwise.
    assign m_f0 = two ? f0_q : fb_rdata;

    blit_row_merge u_merge (
        .s        (s_q),
        .x_bit    (x0_q[2:0]),
        .spill_en (spill_en),
        .f0       (m_f0),
        .f1       (fb_rdata),
        .w0       (m_w0),
        .w1       (m_w1),
        .coll     (m_coll)
    );

    always_comb begin
        state_d    = state_q;
        x0_d       = x0_q;
        y_d        = y_q;
        r_d        = r_q;
        n_d        = n_q;
        s_d        = s_q;
        f0_d       = f0_q;
        coll_d     = coll_q;
        mem_rd_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        fb_rd_d    = 1'b0;
        fb_we_d    = 1'b0;
        fb_addr_d  = fb_addr_q;
        fb_wdata_d = fb_wdata_q;
        row_end    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (draw_start) begin
                    x0_d   = 6'(draw_x % 8'd64);
                    y_d    = 5'(draw_y % 8'd32);
                    n_d    = draw_n;
                    r_d    = 4'd0;
                    coll_d = 1'b0;
                    if (draw_n == 4'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d    = ST_SPR_RD;
                        mem_rd_d   = 1'b1;
                        mem_addr_d = draw_addr;
                    end
                end else if (clear_start) begin
                    state_d    = ST_CLEAR;
                    coll_d     = 1'b0;
                    fb_we_d    = 1'b1;
                    fb_addr_d  = '0;
                    fb_wdata_d = 8'h00;
                end
            end
            ST_CLEAR: begin
                if (fb_addr_q == '1) begin
                    state_d = ST_DONE;
                end else begin
                    fb_we_d   = 1'b1;
                    fb_addr_d = fb_addr_q + FB_AW'(1);
                end
            end
            ST_SPR_RD: begin
                state_d   = ST_FB_RD0;
                fb_rd_d   = 1'b1;
                fb_addr_d = b0;
            end
            ST_FB_RD0: begin
                s_d = mem_data;
                if (two) begin
                    state_d   = ST_FB_RD1;
                    fb_rd_d   = 1'b1;
                    fb_addr_d = b0 + FB_AW'(1);
                end else begin
                    state_d   = ST_WR0;
                    fb_we_d   = 1'b1;
                    fb_addr_d = b0;
                end
            end
            ST_FB_RD1: begin
                f0_d      = fb_rdata;
                state_d   = ST_WR0;
                fb_we_d   = 1'b1;
                fb_addr_d = b0;
            end
            ST_WR0: begin
                coll_d     = coll_q | m_coll;
                fb_wdata_d = m_w1;
                if (two) begin
                    state_d   = ST_WR1;
                    fb_we_d   = 1'b1;
                    fb_addr_d = b0 + FB_AW'(1);
                end else begin
                    row_end = 1'b1;
                end
            end
            ST_WR1: begin
                row_end = 1'b1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Rows below the bottom edge are clipped, so the command ends at row 31.
        if (row_end) begin
            if ((r_q + 4'd1 == n_q) || y_last) begin
                state_d = ST_DONE;
            end else begin
                state_d    = ST_SPR_RD;
                r_d        = r_q + 4'd1;
                y_d        = y_q + 5'd1;
                mem_rd_d   = 1'b1;
                mem_addr_d = mem_addr_q + MEM_AW'(1);
            end
        end

        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            x0_q       <= '0;
            y_q        <= '0;
            r_q        <= '0;
            n_q        <= '0;
            s_q        <= '0;
            f0_q       <= '0;
            coll_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= '0;
            fb_rd_q    <= 1'b0;
            fb_we_q    <= 1'b0;
            fb_addr_q  <= '0;
            fb_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            x0_q       <= x0_d;
            y_q        <= y_d;
            r_q        <= r_d;
            n_q        <= n_d;
            s_q        <= s_d;
            f0_q       <= f0_d;
            coll_q     <= coll_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mem_rd_q   <= mem_rd_d;
            mem_addr_q <= mem_addr_d;
            fb_rd_q    <= fb_rd_d;
            fb_we_q    <= fb_we_d;
            fb_addr_q  <= fb_addr_d;
            fb_wdata_q <= fb_wdata_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign collision = coll_q;
    assign mem_rd    = mem_rd_q;
    assign mem_addr  = mem_addr_q;
    assign fb_rd     = fb_rd_q;
    assign fb_we     = fb_we_q;
    assign fb_addr   = fb_addr_q;
    // First byte depends on data returning this cycle; the spill byte was merged a cycle earlier.
    assign fb_wdata  = (state_q == ST_WR0) ? m_w0 : fb_wdata_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with behavioural sprite memory and framebuffer.
module tb_sprite_blitter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        draw_start = 1'b0;
    logic        clear_start = 1'b0;
    logic [7:0]  draw_x = '0;
    logic [7:0]  draw_y = '0;
    logic [3:0]  draw_n = '0;
    logic [11:0] draw_addr = '0;
    logic        busy, done, collision, mem_rd, fb_rd, fb_we;
    logic [11:0] mem_addr;
    logic [7:0]  mem_data = '0;
    logic [7:0]  fb_addr;
    logic [7:0]  fb_wdata;
    logic [7:0]  fb_rdata = '0;

    logic [7:0]  fb_mem [256];
    logic [7:0]  spr [4096];

    int errs = 0;
    int checks = 0;
    int wr_cnt = 0, rd_cnt = 0, mrd_cnt = 0, order_bad = 0, wdata_nz = 0;
    int busy_cyc = 0;
    bit got_done = 0, done_after_we = 0;

    always #5 clk = ~clk;

    sprite_blitter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .draw_start  (draw_start),
        .clear_start (clear_start),
        .draw_x      (draw_x),
        .draw_y      (draw_y),
        .draw_n      (draw_n),
        .draw_addr   (draw_addr),
        .busy        (busy),
        .done        (done),
        .collision   (collision),
        .mem_rd      (mem_rd),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .fb_rd       (fb_rd),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_wdata    (fb_wdata),
        .fb_rdata    (fb_rdata)
    );

    always @(posedge clk) begin
        if (fb_we) begin
            if (fb_addr != wr_cnt[7:0]) order_bad++;
            if (fb_wdata != 8'h00) wdata_nz++;
            fb_mem[fb_addr] = fb_wdata;
            wr_cnt++;
        end
        if (fb_rd) begin
            fb_rdata <= fb_mem[fb_addr];
            rd_cnt++;
        end
        if (mem_rd) begin
            mem_data <= spr[mem_addr];
            mrd_cnt++;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one command at a negedge and wait (bounded) for done.
    task automatic run_cmd(input bit drw, input bit clr, input logic [7:0] x, input logic [7:0] y,
                           input logic [3:0] n, input logic [11:0] a, input bit poke);
        bit prev_we;
        @(negedge clk);
        wr_cnt = 0; rd_cnt = 0; mrd_cnt = 0; order_bad = 0; wdata_nz = 0;
        draw_start = drw; clear_start = clr;
        draw_x = x; draw_y = y; draw_n = n; draw_addr = a;
        @(negedge clk);
        draw_start = 0; clear_start = 0;
        busy_cyc = 0; got_done = 0; done_after_we = 0; prev_we = 0;
        for (int i = 0; i < 1000; i++) begin
            if (poke && i == 1) begin
                draw_start = 1; clear_start = 1;
                draw_x = 8'd0; draw_y = 8'd0; draw_n = 4'd1; draw_addr = 12'h310;
            end
            if (poke && i == 2) begin
                draw_start = 0; clear_start = 0;
            end
            if (done) begin
                got_done = 1;
                done_after_we = prev_we;
                break;
            end
            if (busy) busy_cyc++;
            prev_we = fb_we;
            @(negedge clk);
        end
        check_eq("done_seen", int'(got_done), 1);
        if (got_done) begin
            check_eq("busy_at_done", int'(busy), 0);
            @(negedge clk);
            check_eq("done_one_cycle", int'(done), 0);
        end
    endtask

    initial begin
        int nz;
        for (int i = 0; i < 4096; i++) spr[i] = 8'h00;
        for (int i = 0; i < 256; i++) fb_mem[i] = 8'hFF;
        spr[12'h300] = 8'hF0;
        spr[12'h310] = 8'hFF;
        spr[12'h320] = 8'h81; spr[12'h321] = 8'h42; spr[12'h322] = 8'h24; spr[12'h323] = 8'h18;

        repeat (2) @(negedge clk);
        check_eq("reset_flags", int'({busy, done, collision, mem_rd, fb_rd, fb_we}), 0);
        check_eq("reset_addrs", int'({mem_addr, fb_addr, fb_wdata}), 0);
        rst_n = 1;

        // clear
        run_cmd(0, 1, 0, 0, 0, 0, 0);
        check_eq("clr_writes", wr_cnt, 256);
        check_eq("clr_order", order_bad, 0);
        check_eq("clr_data", wdata_nz, 0);
        check_eq("clr_busy_cycles", busy_cyc, 256);
        check_eq("clr_done_after_last", int'(done_after_we), 1);
        check_eq("clr_coll", int'(collision), 0);
        nz = 0;
        for (int i = 0; i < 256; i++) if (fb_mem[i] != 8'h00) nz++;
        check_eq("clr_fb_zero", nz, 0);

        // aligned draw, then repeat to erase
        run_cmd(1, 0, 8'd8, 8'd0, 4'd1, 12'h300, 0);
        check_eq("al_fb1", int'(fb_mem[1]), 8'hF0);
        check_eq("al_coll", int'(collision), 0);
        check_eq("al_writes", wr_cnt, 1);
        check_eq("al_busy_cycles", busy_cyc, 3);
        run_cmd(1, 0, 8'd8, 8'd0, 4'd1, 12'h300, 0);
        check_eq("al2_fb1", int'(fb_mem[1]), 8'h00);
        check_eq("al2_coll", int'(collision), 1);

        // N = 0
        run_cmd(1, 0, 8'd8, 8'd0, 4'd0, 12'h300, 0);
        check_eq("n0_strobes", mrd_cnt + rd_cnt + wr_cnt, 0);
        check_eq("n0_coll", int'(collision), 0);
        check_eq("n0_busy_cycles", busy_cyc, 0);

        // unaligned draw, then repeat to erase
        run_cmd(1, 0, 8'd12, 8'd2, 4'd1, 12'h310, 0);
        check_eq("un_fb17", int'(fb_mem[17]), 8'h0F);
        check_eq("un_fb18", int'(fb_mem[18]), 8'hF0);
        check_eq("un_writes", wr_cnt, 2);
        check_eq("un_coll", int'(collision), 0);
        check_eq("un_busy_cycles", busy_cyc, 5);
        run_cmd(1, 0, 8'd12, 8'd2, 4'd1, 12'h310, 0);
        check_eq("un2_fb17_18", int'({fb_mem[17], fb_mem[18]}), 0);
        check_eq("un2_coll", int'(collision), 1);

        // right-edge clip
        run_cmd(1, 0, 8'd60, 8'd0, 4'd1, 12'h310, 0);
        check_eq("clip_fb7", int'(fb_mem[7]), 8'h0F);
        check_eq("clip_fb0", int'(fb_mem[0]), 8'h00);
        check_eq("clip_writes", wr_cnt, 1);
        check_eq("clip_busy_cycles", busy_cyc, 3);

        // coordinate wrap: (70,33) -> (6,1)
        run_cmd(1, 0, 8'd70, 8'd33, 4'd1, 12'h310, 0);
        check_eq("wrap_fb8", int'(fb_mem[8]), 8'h03);
        check_eq("wrap_fb9", int'(fb_mem[9]), 8'hFC);
        check_eq("wrap_coll", int'(collision), 0);

        // bottom clip: y=30, N=4 draws rows 30 and 31 only
        run_cmd(1, 0, 8'd0, 8'd30, 4'd4, 12'h320, 0);
        check_eq("bot_fb240", int'(fb_mem[240]), 8'h81);
        check_eq("bot_fb248", int'(fb_mem[248]), 8'h42);
        check_eq("bot_mem_reads", mrd_cnt, 2);
        check_eq("bot_writes", wr_cnt, 2);
        check_eq("bot_no_wrap_fb0", int'(fb_mem[0]), 8'h00);

        // starts while busy are ignored
        run_cmd(1, 0, 8'd20, 8'd5, 4'd1, 12'h310, 1);
        check_eq("poke_fb42", int'(fb_mem[42]), 8'h0F);
        check_eq("poke_fb43", int'(fb_mem[43]), 8'hF0);
        check_eq("poke_writes", wr_cnt, 2);
        check_eq("poke_fb0", int'(fb_mem[0]), 8'h00);
        repeat (3) @(negedge clk);
        check_eq("poke_idle", int'({busy, done}), 0);

        // draw wins over clear
        run_cmd(1, 1, 8'd0, 8'd3, 4'd1, 12'h300, 0);
        check_eq("both_fb24", int'(fb_mem[24]), 8'hF0);
        check_eq("both_writes", wr_cnt, 1);

        // reset mid-draw, then a normal command
        run_cmd(1, 0, 8'd12, 8'd2, 4'd1, 12'h310, 0);
        run_cmd(1, 0, 8'd12, 8'd2, 4'd1, 12'h310, 0);
        @(negedge clk);
        draw_start = 1; draw_x = 8'd3; draw_y = 8'd10; draw_n = 4'd4; draw_addr = 12'h320;
        @(negedge clk);
        draw_start = 0;
        repeat (3) @(negedge clk);
        #2 rst_n = 0;
        #1;
        check_eq("rst_mid_flags", int'({busy, done, collision, mem_rd, fb_rd, fb_we}), 0);
        check_eq("rst_mid_addrs", int'({mem_addr, fb_addr, fb_wdata}), 0);
        @(negedge clk);
        rst_n = 1;
        run_cmd(1, 0, 8'd0, 8'd20, 4'd1, 12'h300, 0);
        check_eq("post_rst_fb160", int'(fb_mem[160]), 8'hF0);
        check_eq("post_rst_writes", wr_cnt, 1);
        check_eq("post_rst_coll", int'(collision), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
